// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader and the program RAM.
package loader_pkg;

    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 16;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        P_IDLE,
        P_ADDR_HI,
        P_ADDR_LO,
        P_COUNT,
        P_DATA_HI,
        P_DATA_LO,
        P_CHECK
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_serial, samples mid-bit, flags bad stop bits.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state_q, state_d;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_d, err_d;
    logic [7:0]       data_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RX_IDLE;
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            stop_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], rx_serial};
            prev_q     <= rx_s;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_valid <= valid_d;
            byte_data  <= data_d;
            stop_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        data_d  = byte_data;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = RX_START;
            end
            // A start bit that is high again at half-bit was a glitch.
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_ram_loader.sv
// Serial program loader: parses SYNC/ADDR/COUNT/DATA/CHK frames from the UART and
// writes 16-bit words into the program RAM while holding the CPU off the port.
module uart_ram_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_serial,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  checksum_error,
    output logic                  frame_error
);

    localparam int unsigned TMO_CLKS = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int unsigned TMO_W    = $clog2(TMO_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

    logic       byte_valid, stop_err;
    logic [7:0] byte_data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx_serial (rx_serial),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .stop_err  (stop_err)
    );

    parser_state_t         state_q, state_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            hi_q, hi_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  adv_q, adv_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  w_en_d, hold_d, done_d, chk_err_d, frm_err_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] w_data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= P_IDLE;
            sum_q          <= '0;
            hi_q           <= '0;
            cnt_q          <= '0;
            adv_q          <= 1'b0;
            tmo_q          <= '0;
            ram_w_en       <= 1'b0;
            ram_addr       <= '0;
            ram_w_data     <= '0;
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
            load_done      <= 1'b0;
            checksum_error <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sum_q          <= sum_d;
            hi_q           <= hi_d;
            cnt_q          <= cnt_d;
            adv_q          <= adv_d;
            tmo_q          <= tmo_d;
            ram_w_en       <= w_en_d;
            ram_addr       <= addr_d;
            ram_w_data     <= w_data_d;
            cpu_hold       <= hold_d;
            busy           <= hold_d;
            load_done      <= done_d;
            checksum_error <= chk_err_d;
            frame_error    <= frm_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        adv_d     = 1'b0;
        w_en_d    = 1'b0;
        done_d    = 1'b0;
        addr_d    = ram_addr;
        w_data_d  = ram_w_data;
        chk_err_d = checksum_error;
        frm_err_d = frame_error;
        tmo_d     = (state_q == P_IDLE || byte_valid) ? '0 : tmo_q + 1'b1;

        // Post-write bookkeeping runs independently so an abort never drops it.
        if (adv_q) begin
            addr_d = ram_addr + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end

        if (stop_err) begin
            frm_err_d = 1'b1;
            state_d   = P_IDLE;
        end else if (byte_valid) begin
            sum_d = sum_q + byte_data;
            case (state_q)
                P_IDLE: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d   = P_ADDR_HI;
                        chk_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        sum_d     = '0;
                    end
                end
                P_ADDR_HI: begin
                    hi_d    = byte_data;
                    state_d = P_ADDR_LO;
                end
                P_ADDR_LO: begin
                    addr_d  = {hi_q[3:0], byte_data};
                    state_d = P_COUNT;
                end
                P_COUNT: begin
                    cnt_d   = (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
                    state_d = P_DATA_HI;
                end
                P_DATA_HI: begin
                    hi_d    = byte_data;
                    state_d = P_DATA_LO;
                end
                P_DATA_LO: begin
                    w_en_d   = 1'b1;
                    w_data_d = {hi_q, byte_data};
                    adv_d    = 1'b1;
                    state_d  = (cnt_q == 9'd1) ? P_CHECK : P_DATA_HI;
                end
                P_CHECK: begin
                    if (sum_d == 8'd0) done_d = 1'b1;
                    else               chk_err_d = 1'b1;
                    state_d = P_IDLE;
                end
                default: state_d = P_IDLE;
            endcase
        end else if (state_q != P_IDLE && tmo_q == TMO_LAST) begin
            frm_err_d = 1'b1;
            state_d   = P_IDLE;
        end

        hold_d = (state_d != P_IDLE);
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader with a write scoreboard fed by the frame builder.
module tb_uart_ram_loader;

    localparam int unsigned CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        ram_w_en;
    logic [11:0] ram_addr;
    logic [15:0] ram_w_data;
    logic        cpu_hold, busy, load_done, checksum_error, frame_error;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [27:0] exp_q[$];
    logic [7:0]  run_sum;

    uart_ram_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(20)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .rx_serial     (rx),
        .ram_w_en      (ram_w_en),
        .ram_addr      (ram_addr),
        .ram_w_data    (ram_w_data),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .load_done     (load_done),
        .checksum_error(checksum_error),
        .frame_error   (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (ram_w_en === 1'b1) begin
            wr_cnt++;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("write_addr_data", 32'({ram_addr, ram_w_data}), 32'(exp_q.pop_front()));
        end
        if (load_done === 1'b1) done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(CPB);
    endtask

    task automatic body(input logic [7:0] b);
        run_sum = run_sum + b;
        send_byte(b, 1'b0);
    endtask

    task automatic send_chk(input logic [7:0] adj);
        logic [7:0] chk;
        chk = 8'h00 - run_sum;
        chk = chk + adj;
        send_byte(chk, 1'b0);
    endtask

    task automatic send_frame(input logic [11:0] addr, input logic [3:0] junk, input int n,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [7:0] adj, input bit with_sync);
        logic [15:0] w;
        run_sum = 8'h00;
        if (with_sync) send_byte(8'hA5, 1'b0);
        body({junk, addr[11:8]});
        body(addr[7:0]);
        body(8'(n));
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            exp_q.push_back({12'(addr + 12'(i)), w});
            body(w[15:8]);
            body(w[7:0]);
        end
        send_chk(adj);
        wait_clks(4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 32'({ram_w_en, cpu_hold, busy, load_done, checksum_error, frame_error}), 32'd0);
        check({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_data"}, 32'(ram_w_data), 32'd0);
    endtask

    int w0c, d0c;

    initial begin
        rx = 1'b1;
        rst_n = 1'b0;
        wait_clks(5);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_clks(5);

        // Good two-word frame
        w0c = wr_cnt; d0c = done_cnt;
        send_frame(12'h010, 4'h0, 2, 16'h1234, 16'hABCD, 8'h00, 1'b1);
        check("good_writes", 32'(wr_cnt - w0c), 32'd2);
        check("good_done", 32'(done_cnt - d0c), 32'd1);
        check("good_hold", 32'({cpu_hold, busy}), 32'd0);
        check("good_errs", 32'({checksum_error, frame_error}), 32'd0);
        check("good_addr_next", 32'(ram_addr), 32'h012);

        // Bad checksum: writes still commit, error is sticky
        w0c = wr_cnt; d0c = done_cnt;
        send_frame(12'h010, 4'h0, 2, 16'h1234, 16'hABCD, 8'h01, 1'b1);
        check("badchk_writes", 32'(wr_cnt - w0c), 32'd2);
        check("badchk_done", 32'(done_cnt - d0c), 32'd0);
        check("badchk_err", 32'(checksum_error), 32'd1);
        check("badchk_hold", 32'(cpu_hold), 32'd0);

        // Next SYNC clears the error, then a wrapping frame with junk in ADDR_HI[7:4]
        send_byte(8'hA5, 1'b0);
        wait_clks(2);
        check("sync_clears_chk", 32'(checksum_error), 32'd0);
        check("sync_sets_hold", 32'({cpu_hold, busy}), 32'd3);
        w0c = wr_cnt; d0c = done_cnt;
        send_frame(12'hFFF, 4'hC, 2, 16'hBEEF, 16'h0F0F, 8'h00, 1'b0);
        check("wrap_writes", 32'(wr_cnt - w0c), 32'd2);
        check("wrap_done", 32'(done_cnt - d0c), 32'd1);
        check("wrap_addr_next", 32'(ram_addr), 32'h001);

        // Bad stop bit on ADDR_LO
        w0c = wr_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h30, 1'b1);
        wait_clks(4);
        check("stop_ferr", 32'(frame_error), 32'd1);
        check("stop_hold", 32'({cpu_hold, busy}), 32'd0);
        check("stop_writes", 32'(wr_cnt - w0c), 32'd0);

        // Inter-byte timeout after COUNT
        send_byte(8'hA5, 1'b0);
        check("sync_clears_ferr", 32'(frame_error), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_clks(17 * CPB);
        check("tmo_not_yet", 32'({frame_error, cpu_hold}), 32'b01);
        wait_clks(3 * CPB);
        check("tmo_ferr", 32'(frame_error), 32'd1);
        check("tmo_hold", 32'({cpu_hold, busy}), 32'd0);
        w0c = wr_cnt; d0c = done_cnt;
        send_frame(12'h7FE, 4'h0, 1, 16'h0001, 16'h0000, 8'h00, 1'b1);
        check("post_tmo_writes", 32'(wr_cnt - w0c), 32'd1);
        check("post_tmo_done", 32'(done_cnt - d0c), 32'd1);

        // Noise byte while idle is ignored
        send_byte(8'h55, 1'b0);
        wait_clks(2);
        check("noise_idle", 32'({cpu_hold, busy, frame_error}), 32'd0);

        // Quarter-bit glitch mid-frame, and SYNC value as data
        w0c = wr_cnt; d0c = done_cnt;
        run_sum = 8'h00;
        send_byte(8'hA5, 1'b0);
        body(8'h02);
        rx = 1'b0;
        wait_clks(CPB / 4);
        rx = 1'b1;
        wait_clks(2 * CPB);
        check("glitch_busy", 32'({busy, frame_error}), 32'b10);
        body(8'h40);
        body(8'h01);
        exp_q.push_back({12'h240, 16'hA5A5});
        body(8'hA5);
        body(8'hA5);
        send_chk(8'h00);
        wait_clks(4);
        check("glitch_writes", 32'(wr_cnt - w0c), 32'd1);
        check("glitch_done", 32'(done_cnt - d0c), 32'd1);

        // Reset asserted while waiting for DATA_LO
        run_sum = 8'h00;
        send_byte(8'hA5, 1'b0);
        body(8'h01);
        body(8'h00);
        body(8'h02);
        exp_q.push_back({12'h100, 16'h1122});
        body(8'h11);
        body(8'h22);
        body(8'h33);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        w0c = wr_cnt; d0c = done_cnt;
        send_frame(12'h123, 4'h0, 2, 16'hCAFE, 16'h5555, 8'h00, 1'b1);
        check("after_rst_writes", 32'(wr_cnt - w0c), 32'd2);
        check("after_rst_done", 32'(done_cnt - d0c), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
